// File: rtl/ddr_line_bridge.sv
// ddr_line_bridge: splits cache-line read/write requests into BEATS MIG 7-series UI transactions
// Ports: ui_clk_i/rst_ni clock and async active-low reset; init_calib_complete_i gates acceptance;
//   req_* line request handshake (write flag, word address, line data, byte strobes);
//   resp_* one-cycle completion pulse and assembled read line;
//   app_* MIG command, write-data and read-data channels; busy_o is high outside IDLE.
module ddr_line_bridge #(
  parameter int ADDR_W      = 30,
  parameter int UI_DATA_W   = 128,
  parameter int BEATS       = 2,
  parameter int APP_ADDR_W  = 27,
  parameter int BEAT_STRIDE = 16
) (
  input  logic                         ui_clk_i,
  input  logic                         rst_ni,
  input  logic                         init_calib_complete_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [UI_DATA_W*BEATS-1:0]   req_wdata_i,
  input  logic [UI_DATA_W*BEATS/8-1:0] req_wstrb_i,
  output logic                         resp_valid_o,
  output logic [UI_DATA_W*BEATS-1:0]   resp_rdata_o,
  output logic [APP_ADDR_W-1:0]        app_addr_o,
  output logic [2:0]                   app_cmd_o,
  output logic                         app_en_o,
  input  logic                         app_rdy_i,
  output logic [UI_DATA_W-1:0]         app_wdf_data_o,
  output logic [UI_DATA_W/8-1:0]       app_wdf_mask_o,
  output logic                         app_wdf_wren_o,
  output logic                         app_wdf_end_o,
  input  logic                         app_wdf_rdy_i,
  input  logic [UI_DATA_W-1:0]         app_rd_data_i,
  input  logic                         app_rd_data_valid_i,
  output logic                         busy_o
);
  localparam int LINE_W = UI_DATA_W * BEATS;
  localparam int STRB_W = UI_DATA_W / 8;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int IDX_W  = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LSH    = $clog2(LINE_W / 32);
  localparam int BSH    = $clog2(BEATS * BEAT_STRIDE);
  localparam int SSH    = $clog2(BEAT_STRIDE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic write_q, write_d;
  logic [APP_ADDR_W-1:0] base_q, base_d;
  logic [BEATS-1:0][UI_DATA_W-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [BEATS-1:0][STRB_W-1:0] wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d, wdf_cnt_q, wdf_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] wdf_idx, rd_idx;
  logic accept, cmd_fire, wdf_fire, rd_fire, done;
  // Reset gates ready so nothing is offered while the bridge is held in reset.
  assign req_ready_o    = rst_ni && state_q == IDLE && init_calib_complete_i;
  assign accept         = req_valid_i && req_ready_o;
  assign app_en_o       = state_q == BUSY && cmd_cnt_q < LAST;
  assign cmd_fire       = app_en_o && app_rdy_i;
  assign app_wdf_wren_o = state_q == BUSY && write_q && wdf_cnt_q < LAST;
  assign app_wdf_end_o  = app_wdf_wren_o;
  assign wdf_fire       = app_wdf_wren_o && app_wdf_rdy_i;
  // Beats outside a read transaction (including stragglers after reset) are dropped.
  assign rd_fire        = state_q == BUSY && !write_q && app_rd_data_valid_i && rd_cnt_q < LAST;
  assign wdf_idx        = IDX_W'(wdf_cnt_q);
  assign rd_idx         = IDX_W'(rd_cnt_q);
  assign app_addr_o     = base_q + (APP_ADDR_W'(cmd_cnt_q) << SSH);
  assign app_cmd_o      = write_q ? 3'b000 : 3'b001;
  assign app_wdf_data_o = wdata_q[wdf_idx];
  assign app_wdf_mask_o = ~wstrb_q[wdf_idx];
  assign resp_valid_o   = state_q == RESP;
  assign resp_rdata_o   = rdata_q;
  assign busy_o         = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    cmd_cnt_d = cmd_cnt_q + CNT_W'(cmd_fire);
    wdf_cnt_d = wdf_cnt_q + CNT_W'(wdf_fire);
    rd_cnt_d  = rd_cnt_q + CNT_W'(rd_fire);
    rbuf_d    = rbuf_q;
    if (rd_fire) rbuf_d[rd_idx] = app_rd_data_i;
    // Exit looks at next-state counters so the finishing handshake counts this cycle.
    done = write_q ? (cmd_cnt_d == LAST && wdf_cnt_d == LAST) : rd_cnt_d == LAST;
    if (state_q == IDLE && accept) begin
      state_d   = BUSY;
      write_d   = req_write_i;
      base_d    = APP_ADDR_W'({{BSH{1'b0}}, req_addr_i >> LSH} << BSH);
      wdata_d   = req_wdata_i;
      wstrb_d   = req_wstrb_i;
      cmd_cnt_d = '0;
      wdf_cnt_d = '0;
      rd_cnt_d  = '0;
    end else if (state_q == BUSY && done) begin
      state_d = RESP;
      rdata_d = write_q ? rdata_q : rbuf_d;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge ui_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
      cmd_cnt_q <= '0;
      wdf_cnt_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rbuf_q    <= rbuf_d;
      rdata_q   <= rdata_d;
      cmd_cnt_q <= cmd_cnt_d;
      wdf_cnt_q <= wdf_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end
endmodule
